ledpanel_wr_ctrl: RTL
=====================

Name: ledpanel_wr_ctrl

Overview:
Write-port controller for the 32x32 LED panel framebuffer. It sits between the CPU memory/IO bus and the panel write port (wr_enable/wr_addr_x/wr_addr_y/wr_rgb_data). It combines two write sources: direct CPU pixel writes, and a hardware rectangle-fill engine the CPU configures through registers. A fixed-priority arbiter merges both onto the single write port.

Parameters:
COORD_BITS, 5, width of the x and y coordinates (panel is 2^COORD_BITS square)
CNT_BITS, 11, width of the pixel counter; must hold (2^COORD_BITS)^2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_valid  in  1  bus request; held until cpu_ready
cpu_write  in  1  1 = write, 0 = read
cpu_addr  in  12  word address within the block window
cpu_wdata  in  32  write data
cpu_ready  out  1  one-cycle acknowledge
cpu_rdata  out  32  read data; valid while cpu_ready=1
wr_enable  out  1  panel write strobe
wr_addr_x  out  COORD_BITS  panel x
wr_addr_y  out  COORD_BITS  panel y
wr_rgb_data  out  24  panel colour
busy  out  1  fill engine active
done  out  1  one-cycle pulse when a fill completes normally

Behaviour:
- Reset: all outputs 0; state IDLE; XY0, XY1, COLOR, count and err cleared to 0. A reset mid-fill abandons the fill with no done pulse.
- Bus acceptance: a request is accepted when cpu_valid=1 and cpu_ready=0. cpu_ready goes high the following cycle for exactly one cycle. Accesses are never stalled.
- Address map:
  - cpu_addr[11]=0: direct pixel write. {y,x} = cpu_addr[2*COORD_BITS-1:0], colour = cpu_wdata[23:0]. A read returns 0.
  - 0x800 XY0 = {y0[12:8], x0[4:0]}, read/write.
  - 0x801 XY1 = {y1, x1}, same layout, read/write.
  - 0x802 COLOR = [23:0], read/write.
  - 0x803 CTRL/STATUS:
    - Write: bit0 start, bit1 abort, bit2 clear err.
    - Read: bit0 busy, bit1 err, [16+CNT_BITS-1:16] pixels written by the current or last fill.
  - Any other address: write ignored, read returns 0.
- Direct write latency: accept at cycle T gives wr_enable=1 with the pixel at cycle T+1, together with cpu_ready.
- FSM states: IDLE, FILL, DONE.
  - IDLE to FILL: a start write while IDLE. At that point the engine latches:
    - x_lo = min(x0,x1), x_hi = max(x0,x1)
    - y_lo = min(y0,y1), y_hi = max(y0,y1)
    - colour from COLOR
  - It also sets cx=x_lo, cy=y_lo, count=0. busy=1 from T+1.
  - FILL: each cycle with no direct CPU write being issued, the engine drives wr_enable=1 at (cx,cy) with the latched colour, then increments count.
    - Traversal is row-major: cx++; at cx==x_hi, cx=x_lo and cy++.
    - The write of (x_hi,y_hi) moves to DONE.
    - First engine pixel appears at T+2.
  - DONE: one cycle; done=1, busy=0; then IDLE.
  - Abort write during FILL: FILL to IDLE on the next edge, no done pulse, count keeps its value. Abort while IDLE has no effect.
- Start while FILL or DONE: ignored; err set (sticky until cleared by a CTRL bit2 write).
- Start and abort together in one write: abort wins; no new fill starts.
- Register writes during FILL change the registers only. The active fill uses its latched copies.
- Arbitration:
  - Direct CPU write has fixed priority. The engine stalls that cycle: cx, cy and count hold, and no pixel is lost or duplicated.
  - Maximum one write per cycle on the panel port.
- Degenerate rectangle x0==x1 and y0==y1: exactly one pixel, then DONE.
- Full panel (0,0)–(31,31): 1024 pixels, count=1024. Uninterrupted, this takes 1024 consecutive wr_enable cycles.
- wr_addr_x, wr_addr_y and wr_rgb_data hold their last values when wr_enable=0.

Test Plan:
- Reset → all outputs 0. Read 0x803 returns 0. Read 0x800 returns 0.
- Direct write addr 0x065, data 0xFF8040 → next cycle wr_enable=1, x=5, y=3, rgb=0xFF8040, cpu_ready=1, busy stays 0.
- XY0=(3,2), XY1=(2,1) (swapped corners), COLOR=0x00FF00, start → exactly 4 writes in order (2,1),(3,1),(2,2),(3,2), all 0x00FF00. Then done pulse and STATUS count=4.
- Full-panel fill with one direct write to (0,31) injected at fill cycle 100:
  - 1025 writes total; engine pixel 100 is delayed one cycle; no engine coordinate is repeated or skipped.
  - done occurs 1 cycle later than the uninterrupted case.
- Start during fill → err=1, fill unaffected. Then CTRL=0x4 → err=0.
- Abort after 10 engine pixels of a 32x32 fill → busy=0 next cycle, no done pulse, STATUS count=10, no further engine writes.

Source files
------------

// File: rtl/ledpanel_wr_ctrl.sv
// Write-port controller for the LED panel framebuffer: merges direct CPU pixel
// writes and a register-driven rectangle-fill engine onto one panel write port.
module ledpanel_wr_ctrl #(
   parameter int COORD_BITS = 5,
   parameter int CNT_BITS   = 11
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_valid,
   input  logic                  cpu_write,
   input  logic [11:0]           cpu_addr,
   input  logic [31:0]           cpu_wdata,
   output logic                  cpu_ready,
   output logic [31:0]           cpu_rdata,
   output logic                  wr_enable,
   output logic [COORD_BITS-1:0] wr_addr_x,
   output logic [COORD_BITS-1:0] wr_addr_y,
   output logic [23:0]           wr_rgb_data,
   output logic                  busy,
   output logic                  done
);

   localparam int CB = COORD_BITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bus handshake: a request is taken when cpu_valid=1 and cpu_ready=0; the
   // acknowledge (and read data) follows for exactly one cycle, never stalled.
   state_t              state_q, state_d;
   logic                cpu_ready_q, cpu_ready_d;
   logic [31:0]         cpu_rdata_q, cpu_rdata_d;
   logic                wr_enable_q, wr_enable_d;
   logic [CB-1:0]       wr_x_q, wr_x_d;
   logic [CB-1:0]       wr_y_q, wr_y_d;
   logic [23:0]         wr_rgb_q, wr_rgb_d;
   logic [CB-1:0]       x0_q, x0_d, y0_q, y0_d;
   logic [CB-1:0]       x1_q, x1_d, y1_q, y1_d;
   logic [23:0]         color_q, color_d;
   logic [CB-1:0]       x_lo_q, x_lo_d, x_hi_q, x_hi_d;
   logic [CB-1:0]       y_lo_q, y_lo_d, y_hi_q, y_hi_d;
   logic [23:0]         fill_rgb_q, fill_rgb_d;
   logic [CB-1:0]       cx_q, cx_d, cy_q, cy_d;
   logic [CNT_BITS-1:0] count_q, count_d;
   logic                err_q, err_d;

   logic       acc, wr_acc, rd_acc, reg_hit, direct_wr, ctrl_wr;
   logic       start_req, abort_req, clear_req;
   logic [1:0] reg_sel;
   logic       unused_wdata;

   assign unused_wdata = ^cpu_wdata[31:24];

   assign acc       = cpu_valid & ~cpu_ready_q;
   assign wr_acc    = acc & cpu_write;
   assign rd_acc    = acc & ~cpu_write;
   assign reg_hit   = cpu_addr[11] & (cpu_addr[10:2] == 9'd0);
   assign reg_sel   = cpu_addr[1:0];
   assign direct_wr = wr_acc & ~cpu_addr[11];
   assign ctrl_wr   = wr_acc & reg_hit & (reg_sel == 2'd3);
   assign start_req = ctrl_wr & cpu_wdata[0];
   assign abort_req = ctrl_wr & cpu_wdata[1];
   assign clear_req = ctrl_wr & cpu_wdata[2];

   always_comb begin
      state_d     = state_q;
      cpu_ready_d = acc;
      cpu_rdata_d = 32'd0;
      wr_enable_d = 1'b0;
      wr_x_d      = wr_x_q;
      wr_y_d      = wr_y_q;
      wr_rgb_d    = wr_rgb_q;
      x0_d        = x0_q;
      y0_d        = y0_q;
      x1_d        = x1_q;
      y1_d        = y1_q;
      color_d     = color_q;
      x_lo_d      = x_lo_q;
      x_hi_d      = x_hi_q;
      y_lo_d      = y_lo_q;
      y_hi_d      = y_hi_q;
      fill_rgb_d  = fill_rgb_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      count_d     = count_q;
      err_d       = clear_req ? 1'b0 : err_q;

      if (rd_acc && reg_hit) begin
         case (reg_sel)
            2'd0: begin
               cpu_rdata_d[0 +: CB] = x0_q;
               cpu_rdata_d[8 +: CB] = y0_q;
            end
            2'd1: begin
               cpu_rdata_d[0 +: CB] = x1_q;
               cpu_rdata_d[8 +: CB] = y1_q;
            end
            2'd2: cpu_rdata_d[23:0] = color_q;
            default: begin
               cpu_rdata_d[0]              = (state_q == FILL);
               cpu_rdata_d[1]              = err_q;
               cpu_rdata_d[16 +: CNT_BITS] = count_q;
            end
         endcase
      end

      if (wr_acc && reg_hit) begin
         case (reg_sel)
            2'd0: begin
               x0_d = cpu_wdata[0 +: CB];
               y0_d = cpu_wdata[8 +: CB];
            end
            2'd1: begin
               x1_d = cpu_wdata[0 +: CB];
               y1_d = cpu_wdata[8 +: CB];
            end
            2'd2: color_d = cpu_wdata[23:0];
            default: ;
         endcase
      end

      // Direct writes own the port; the engine simply skips that cycle.
      if (direct_wr) begin
         wr_enable_d = 1'b1;
         wr_x_d      = cpu_addr[0 +: CB];
         wr_y_d      = cpu_addr[CB +: CB];
         wr_rgb_d    = cpu_wdata[23:0];
      end

      case (state_q)
         IDLE: begin
            if (start_req && !abort_req) begin
               x_lo_d     = (x0_q < x1_q) ? x0_q : x1_q;
               x_hi_d     = (x0_q < x1_q) ? x1_q : x0_q;
               y_lo_d     = (y0_q < y1_q) ? y0_q : y1_q;
               y_hi_d     = (y0_q < y1_q) ? y1_q : y0_q;
               cx_d       = (x0_q < x1_q) ? x0_q : x1_q;
               cy_d       = (y0_q < y1_q) ? y0_q : y1_q;
               fill_rgb_d = color_q;
               count_d    = '0;
               state_d    = FILL;
            end
         end
         FILL: begin
            if (abort_req) begin
               state_d = IDLE;
            end else begin
               if (start_req) err_d = 1'b1;
               if (!direct_wr) begin
                  wr_enable_d = 1'b1;
                  wr_x_d      = cx_q;
                  wr_y_d      = cy_q;
                  wr_rgb_d    = fill_rgb_q;
                  count_d     = count_q + CNT_BITS'(1);
                  if (cx_q == x_hi_q) begin
                     cx_d = x_lo_q;
                     if (cy_q == y_hi_q) state_d = DONE;
                     else cy_d = cy_q + CB'(1);
                  end else begin
                     cx_d = cx_q + CB'(1);
                  end
               end
            end
         end
         DONE: begin
            if (start_req && !abort_req) err_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cpu_ready_q <= 1'b0;
         cpu_rdata_q <= 32'd0;
         wr_enable_q <= 1'b0;
         wr_x_q      <= '0;
         wr_y_q      <= '0;
         wr_rgb_q    <= 24'd0;
         x0_q        <= '0;
         y0_q        <= '0;
         x1_q        <= '0;
         y1_q        <= '0;
         color_q     <= 24'd0;
         x_lo_q      <= '0;
         x_hi_q      <= '0;
         y_lo_q      <= '0;
         y_hi_q      <= '0;
         fill_rgb_q  <= 24'd0;
         cx_q        <= '0;
         cy_q        <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cpu_ready_q <= cpu_ready_d;
         cpu_rdata_q <= cpu_rdata_d;
         wr_enable_q <= wr_enable_d;
         wr_x_q      <= wr_x_d;
         wr_y_q      <= wr_y_d;
         wr_rgb_q    <= wr_rgb_d;
         x0_q        <= x0_d;
         y0_q        <= y0_d;
         x1_q        <= x1_d;
         y1_q        <= y1_d;
         color_q     <= color_d;
         x_lo_q      <= x_lo_d;
         x_hi_q      <= x_hi_d;
         y_lo_q      <= y_lo_d;
         y_hi_q      <= y_hi_d;
         fill_rgb_q  <= fill_rgb_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         count_q     <= count_d;
         err_q       <= err_d;
      end
   end

   assign cpu_ready   = cpu_ready_q;
   assign cpu_rdata   = cpu_rdata_q;
   assign wr_enable   = wr_enable_q;
   assign wr_addr_x   = wr_x_q;
   assign wr_addr_y   = wr_y_q;
   assign wr_rgb_data = wr_rgb_q;
   assign busy        = (state_q == FILL);
   assign done        = (state_q == DONE);

endmodule
